// File: rtl/ysyx_22040237_ifu_fetch_pkg.sv
// rtl/ysyx_22040237_ifu_fetch_pkg.sv - shared widths and reset PC for the fetch unit
package ysyx_22040237_ifu_fetch_pkg;

    // Core-wide register and instruction widths
    localparam int          REG_WIDTH        = 64;
    localparam int          INST_WIDTH       = 32;

    // First fetch address after reset
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

    // Sequential fetch advances one 32-bit instruction at a time
    localparam int          PC_STEP          = 4;

endpackage

// File: rtl/ysyx_22040237_ifu_fifo.sv
// rtl/ysyx_22040237_ifu_fifo.sv - parametrised synchronous FIFO with flush and occupancy count
module ysyx_22040237_ifu_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign do_pop   = pop && (count_q != '0);
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    // Next pointers and occupancy; flush empties the queue and overrides push/pop
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Control state, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: entries are only read while count is non-zero
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    // Callers size their credit so a push never meets a full queue
    assert property (@(posedge clk) disable iff (!rst) !(push && !flush && full && !pop));

endmodule

// File: rtl/ysyx_22040237_ifu_fetch.sv
// rtl/ysyx_22040237_ifu_fetch.sv - decoupled instruction fetch: PC, request issue, response buffering, redirect
module ysyx_22040237_ifu_fetch
    import ysyx_22040237_ifu_fetch_pkg::*;
#(
    parameter int              XLEN     = REG_WIDTH,
    parameter int              INST_W   = INST_WIDTH,
    parameter int              BUS_W    = 64,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [XLEN-1:0]   req_addr,
    input  logic              resp_valid,
    input  logic [BUS_W-1:0]  resp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    // Discards can pile up across back-to-back redirects, so allow headroom beyond DEPTH
    localparam int DROP_W = CNT_W + 3;
    localparam int LANES  = BUS_W / INST_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int IB     = $clog2(INST_W / 8);
    localparam int ENT_W  = XLEN + INST_W;

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  live_q, live_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  addr_count;
    logic [ENT_W-1:0]  fifo_head;
    logic [XLEN-1:0]   rsp_addr;
    logic [INST_W-1:0] resp_inst;
    logic [CNT_W:0]    credit_used;
    logic              req_fire;
    logic              resp_drop;
    logic              resp_keep;

    // Every live request holds a FIFO slot, so issue stops once live + buffered reaches DEPTH
    assign credit_used = {1'b0, live_q} + {1'b0, fifo_count};
    assign req_valid   = rst && !redirect_valid && (credit_used < (CNT_W + 1)'(DEPTH));
    assign req_addr    = pc_q;
    assign req_fire    = req_valid && req_ready;

    // Stale responses (pending discards, or arriving in the redirect cycle) never reach the FIFO
    assign resp_drop   = resp_valid && (redirect_valid || (drop_q != '0));
    assign resp_keep   = resp_valid && !resp_drop;

    assign out_valid   = (fifo_count != '0);
    assign out_pc      = out_valid ? fifo_head[INST_W +: XLEN] : '0;
    assign out_inst    = out_valid ? fifo_head[INST_W-1:0]     : '0;

    // Pick the instruction lane of the bus word using the request address offset
    generate
        if (LANES > 1) begin : g_lanes
            logic [INST_W-1:0] lanes [LANES];
            for (genvar i = 0; i < LANES; i++) begin : g_lane
                assign lanes[i] = resp_data[i*INST_W +: INST_W];
            end
            assign resp_inst = lanes[rsp_addr[IB +: LANE_W]];
        end else begin : g_single
            assign resp_inst = resp_data;
        end
    endgenerate

    // Addresses of live requests in issue order; flushed on redirect since stale responses are never kept
    ysyx_22040237_ifu_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_addr_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (resp_keep),
        .pop_data  (rsp_addr),
        .count     (addr_count)
    );

    // Instruction buffer toward the IDU; a pop in the redirect cycle still completes on the bus
    ysyx_22040237_ifu_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (resp_keep),
        .push_data ({rsp_addr, resp_inst}),
        .pop       (out_ready),
        .pop_data  (fifo_head),
        .count     (fifo_count)
    );

    // PC, live-request and discard bookkeeping
    always_comb begin
        pc_d   = pc_q;
        live_d = live_q;
        drop_d = drop_q;
        if (redirect_valid) begin
            pc_d   = redirect_pc;
            live_d = '0;
            // This cycle's response retires one outstanding request whether it was stale or live
            drop_d = drop_q + DROP_W'(live_q) - DROP_W'(resp_valid);
        end else begin
            if (req_fire) pc_d = pc_q + XLEN'(PC_STEP);
            live_d = live_q + CNT_W'(req_fire) - CNT_W'(resp_keep);
            if (resp_drop) drop_d = drop_q - DROP_W'(1);
        end
    end

    // Fetch state registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q   <= RESET_PC;
            live_q <= '0;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            live_q <= live_d;
            drop_q <= drop_d;
        end
    end

    assert property (@(posedge clk) disable iff (!rst) redirect_valid |-> (redirect_pc[1:0] == 2'b00));
    assert property (@(posedge clk) disable iff (!rst) addr_count == live_q);

endmodule
